// File: rtl/err_prio_pkg.sv
// ---------------------------------------------------------------------------
// err_prio_pkg
// Shared types and helpers for the error-priority arbiter.
//   state_e : arbiter FSM state encoding (IDLE / REPORT)
//   idx_w   : width of an index into N sources (at least 1 bit)
// ---------------------------------------------------------------------------
package err_prio_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/err_prio_sel.sv
// ---------------------------------------------------------------------------
// err_prio_sel
// Combinational winner select over an eligible vector. Highest priority wins;
// on equal priority the lower index wins. Built as a binary tree of
// (prio, idx) compare nodes, padded up to a power-of-two leaf count.
// Ports:
//   i_elig     [N_ERR]          eligible sources
//   i_cfg_prio [N_ERR*PRIO_W]   packed per-source priority
//   o_any                       at least one source eligible
//   o_idx      [IDX_W]          index of the winner (valid when o_any)
// ---------------------------------------------------------------------------
module err_prio_sel
    import err_prio_pkg::*;
#(
    parameter  int N_ERR  = 32,
    parameter  int PRIO_W = 5,
    localparam int IDX_W  = idx_w(N_ERR)
) (
    input  logic [N_ERR-1:0]        i_elig,
    input  logic [N_ERR*PRIO_W-1:0] i_cfg_prio,
    output logic                    o_any,
    output logic [IDX_W-1:0]        o_idx
);

    localparam int LEAVES = 1 << IDX_W;

    for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
        localparam int NODES = LEAVES >> l;
        logic [NODES-1:0] w_v;
        logic [PRIO_W-1:0] w_p [NODES];
        logic [IDX_W-1:0]  w_x [NODES];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NODES; i++) begin : g_i
                if (i < N_ERR) begin : g_real
                    assign w_v[i] = i_elig[i];
                    assign w_p[i] = i_cfg_prio[i*PRIO_W +: PRIO_W];
                end else begin : g_pad
                    assign w_v[i] = 1'b0;
                    assign w_p[i] = '0;
                end
                assign w_x[i] = IDX_W'(i);
            end
        end else begin : g_node
            for (genvar j = 0; j < NODES; j++) begin : g_j
                logic w_pick_r;
                // Right child only wins with strictly higher priority, so the
                // lower-index (left) subtree keeps ties.
                assign w_pick_r = g_lvl[l-1].w_v[2*j+1] &&
                                  (!g_lvl[l-1].w_v[2*j] ||
                                   (g_lvl[l-1].w_p[2*j+1] > g_lvl[l-1].w_p[2*j]));
                assign w_v[j] = g_lvl[l-1].w_v[2*j] | g_lvl[l-1].w_v[2*j+1];
                assign w_p[j] = w_pick_r ? g_lvl[l-1].w_p[2*j+1] : g_lvl[l-1].w_p[2*j];
                assign w_x[j] = w_pick_r ? g_lvl[l-1].w_x[2*j+1] : g_lvl[l-1].w_x[2*j];
            end
        end
    end

    assign o_any = g_lvl[IDX_W].w_v[0];
    assign o_idx = g_lvl[IDX_W].w_x[0];

endmodule

// File: rtl/err_priority_arb.sv
// ---------------------------------------------------------------------------
// err_priority_arb
// Latches error requests into sticky pending bits and reports them one at a
// time, highest configured priority first, over a valid/ready handshake.
// A report in flight is held unchanged until accepted.
//
// Optional feature macro: ERR_PRIO_DROP_CNT_EN adds a saturating counter of
// cycles in which a request hit an already-pending source (i_drop_clr,
// o_drop_cnt, parameter CNT_W).
//
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_err_in          level error requests
//   i_err_mask        1 = source masked (blocks set and selection)
//   i_cfg_prio        packed per-source priority, larger wins
//   o_rpt_valid       report available
//   i_rpt_ready       consumer accepts report
//   o_rpt_idx         reported source index
//   o_rpt_onehot      one-hot of o_rpt_idx
//   o_rpt_prio        priority of reported source, captured at load
//   o_pending         sticky pending register
//   i_drop_clr        clear drop counter (macro only)
//   o_drop_cnt        saturating drop count (macro only)
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | no report in flight; load winner if any eligible
// ST_REPORT | report valid; rpt_* frozen until handshake
// ---------------------------------------------------------------------------
module err_priority_arb
    import err_prio_pkg::*;
#(
    parameter  int N_ERR  = 32,
    parameter  int PRIO_W = 5,
`ifdef ERR_PRIO_DROP_CNT_EN
    parameter  int CNT_W  = 8,
`endif
    localparam int IDX_W  = idx_w(N_ERR)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_ERR-1:0]        i_err_in,
    input  logic [N_ERR-1:0]        i_err_mask,
    input  logic [N_ERR*PRIO_W-1:0] i_cfg_prio,
    output logic                    o_rpt_valid,
    input  logic                    i_rpt_ready,
    output logic [IDX_W-1:0]        o_rpt_idx,
    output logic [N_ERR-1:0]        o_rpt_onehot,
    output logic [PRIO_W-1:0]       o_rpt_prio,
    output logic [N_ERR-1:0]        o_pending
`ifdef ERR_PRIO_DROP_CNT_EN
    ,
    input  logic                    i_drop_clr,
    output logic [CNT_W-1:0]        o_drop_cnt
`endif
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_load;
    logic                w_hs;

    logic [N_ERR-1:0]    r_pending;
    logic [IDX_W-1:0]    r_idx;
    logic [N_ERR-1:0]    r_onehot;
    logic [PRIO_W-1:0]   r_prio;

    logic [N_ERR-1:0]    w_elig;
    logic [N_ERR-1:0]    w_set_vec;
    logic [N_ERR-1:0]    w_clr_vec;
    logic                w_sel_any;
    logic [IDX_W-1:0]    w_sel_idx;

    // Pending but masked sources stay latched and simply sit out selection.
    assign w_elig    = r_pending & ~i_err_mask;
    assign w_set_vec = i_err_in & ~i_err_mask;
    assign w_clr_vec = w_hs ? r_onehot : '0;

    err_prio_sel #(
        .N_ERR  (N_ERR),
        .PRIO_W (PRIO_W)
    ) u_sel (
        .i_elig     (w_elig),
        .i_cfg_prio (i_cfg_prio),
        .o_any      (w_sel_any),
        .o_idx      (w_sel_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_sel_any)   w_state_nxt = ST_REPORT;
            ST_REPORT: if (i_rpt_ready) w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_hs   = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_load = w_sel_any;
            ST_REPORT: w_hs   = i_rpt_ready;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx    <= '0;
            r_onehot <= '0;
            r_prio   <= '0;
        end else if (w_load) begin
            r_idx    <= w_sel_idx;
            r_onehot <= {{(N_ERR-1){1'b0}}, 1'b1} << w_sel_idx;
            r_prio   <= i_cfg_prio[w_sel_idx*PRIO_W +: PRIO_W];
        end
    end

    // A new request on the source being accepted re-arms it (set beats clear).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
        end
    end

`ifdef ERR_PRIO_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_drop;

    assign w_drop = |(w_set_vec & r_pending & ~w_clr_vec);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else if (i_drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_rpt_valid  = (r_state == ST_REPORT);
    assign o_rpt_idx    = r_idx;
    assign o_rpt_onehot = r_onehot;
    assign o_rpt_prio   = r_prio;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_err_priority_arb.sv
module tb_err_priority_arb;

    localparam int N  = 32;
    localparam int PW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  err_in;
    logic [N-1:0]  err_mask;
    logic [N*PW-1:0] cfg;
    logic          ready;
    logic          drop_clr;

    logic          rpt_valid;
    logic [4:0]    rpt_idx;
    logic [N-1:0]  rpt_onehot;
    logic [PW-1:0] rpt_prio;
    logic [N-1:0]  pending;
`ifdef ERR_PRIO_DROP_CNT_EN
    logic [CW-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    err_priority_arb #(
        .N_ERR  (N),
        .PRIO_W (PW)
`ifdef ERR_PRIO_DROP_CNT_EN
        , .CNT_W (CW)
`endif
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_err_in     (err_in),
        .i_err_mask   (err_mask),
        .i_cfg_prio   (cfg),
        .o_rpt_valid  (rpt_valid),
        .i_rpt_ready  (ready),
        .o_rpt_idx    (rpt_idx),
        .o_rpt_onehot (rpt_onehot),
        .o_rpt_prio   (rpt_prio),
        .o_pending    (pending)
`ifdef ERR_PRIO_DROP_CNT_EN
        , .i_drop_clr (drop_clr)
        , .o_drop_cnt (drop_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "rst";

    // Reference model: a set of outstanding sources plus the one report in flight.
    logic [N-1:0] m_pend;
    bit           m_valid;
    int           m_idx;
    logic [N-1:0] m_onehot;
    int           m_prio;
    int           m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=0x%0h exp=0x%0h", phase, tag, got, exp);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'(cfg[i*PW +: PW]);
    endfunction

    function automatic int winner(input logic [N-1:0] elig);
        int best = -1;
        for (int i = 0; i < N; i++)
            if (elig[i] && (best < 0 || prio_of(i) > prio_of(best))) best = i;
        return best;
    endfunction

    task automatic model_update();
        logic [N-1:0] set_v, clr_v;
        int w;
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_idx = 0; m_onehot = '0; m_prio = 0; m_cnt = 0;
        end else begin
            set_v = err_in & ~err_mask;
            clr_v = (m_valid && ready) ? (32'h1 << m_idx) : '0;
            if (drop_clr) m_cnt = 0;
            else if (((set_v & m_pend & ~clr_v) != 0) && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_valid) begin
                if (ready) m_valid = 0;
            end else begin
                w = winner(m_pend & ~err_mask);
                if (w >= 0) begin
                    m_valid = 1; m_idx = w; m_onehot = 32'h1 << w; m_prio = prio_of(w);
                end
            end
            m_pend = (m_pend & ~clr_v) | set_v;
        end
    endtask

    task automatic check_outputs();
        chk("valid",   32'(rpt_valid),  32'(m_valid));
        chk("idx",     32'(rpt_idx),    32'(m_idx));
        chk("onehot",  32'(rpt_onehot), 32'(m_onehot));
        chk("prio",    32'(rpt_prio),   32'(m_prio));
        chk("pending", 32'(pending),    32'(m_pend));
`ifdef ERR_PRIO_DROP_CNT_EN
        chk("drop",    32'(drop_cnt),   32'(m_cnt));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; err_in = '0; err_mask = '0; ready = 1'b0; drop_clr = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_prio(input int i, input int p);
        cfg[i*PW +: PW] = PW'(p);
    endtask

    initial begin
        cfg = '0;
        rst_n = 1'b0; err_in = '0; err_mask = '0; ready = 1'b0; drop_clr = 1'b0;
        m_pend = '0; m_valid = 0; m_idx = 0; m_onehot = '0; m_prio = 0; m_cnt = 0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid",   32'(rpt_valid), 32'd0);
        chk("rst_pending", 32'(pending),   32'd0);

        phase = "ord";
        for (int i = 0; i < N; i++) set_prio(i, i);
        err_in = 32'h9; ready = 1'b1;
        step();
        err_in = '0;
        step();
        chk("first_idx",    32'(rpt_idx),    32'd3);
        chk("first_onehot", 32'(rpt_onehot), 32'h8);
        chk("first_prio",   32'(rpt_prio),   32'd3);
        step();
        step();
        chk("second_idx",    32'(rpt_idx),    32'd0);
        chk("second_onehot", 32'(rpt_onehot), 32'h1);
        step();
        chk("end_pending", 32'(pending),   32'd0);
        chk("end_valid",   32'(rpt_valid), 32'd0);

        phase = "tie";
        do_reset();
        for (int i = 0; i < N; i++) set_prio(i, 7);
        err_in = 32'h8000_0010; ready = 1'b1;
        step();
        err_in = '0;
        step();
        chk("first_idx", 32'(rpt_idx), 32'd4);
        step();
        step();
        chk("second_idx", 32'(rpt_idx), 32'd31);
        step();

        phase = "hold";
        do_reset();
        cfg = '0; set_prio(5, 2); set_prio(20, 9);
        err_in = 32'h1 << 5;
        step();
        err_in = 32'h1 << 20;
        step();
        err_in = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("held_idx",   32'(rpt_idx),   32'd5);
            chk("held_valid", 32'(rpt_valid), 32'd1);
        end
        ready = 1'b1;
        step();
        step();
        chk("next_idx", 32'(rpt_idx), 32'd20);
        step();

        phase = "setwin";
        do_reset();
        err_in = 32'h1 << 5;
        step();
        step();
        chk("first_idx", 32'(rpt_idx), 32'd5);
        ready = 1'b1;
        step();
        chk("pend5", 32'(pending[5]), 32'd1);
        ready = 1'b0;
        step();
        chk("rerpt_valid", 32'(rpt_valid), 32'd1);
        chk("rerpt_idx",   32'(rpt_idx),   32'd5);
        err_in = '0;

        phase = "mask";
        do_reset();
        err_mask = 32'h1; err_in = 32'h1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("masked_pending", 32'(pending),   32'd0);
            chk("masked_valid",   32'(rpt_valid), 32'd0);
        end
        err_mask = '0;
        step();
        err_in = '0; err_mask = 32'h1;
        step();
        chk("retained", 32'(pending[0]), 32'd1);
        chk("suppressed", 32'(rpt_valid), 32'd0);
        err_mask = '0;
        step();
        chk("unmask_valid", 32'(rpt_valid), 32'd1);
        chk("unmask_idx",   32'(rpt_idx),   32'd0);

        phase = "rstmid";
        err_in = 32'hF0;
        step();
        err_in = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("valid",   32'(rpt_valid), 32'd0);
        chk("pending", 32'(pending),   32'd0);

`ifdef ERR_PRIO_DROP_CNT_EN
        phase = "drop";
        do_reset();
        err_in = 32'h1 << 3;
        for (int k = 0; k < 6; k++) step();
        chk("sat", 32'(drop_cnt), 32'd3);
        err_in = '0; drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("clr", 32'(drop_cnt), 32'd0);
`endif

        phase = "rand";
        do_reset();
        for (int k = 0; k < 400; k++) begin
            err_in   = $urandom & $urandom & $urandom;
            err_mask = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
            ready    = $urandom_range(0, 1) == 1;
            drop_clr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < N; i++) set_prio(i, $urandom_range(0, 31));
            rst_n    = $urandom_range(0, 99) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/err_priority_arb.md
# err_priority_arb

Parametrised, sequential error-priority arbiter: latches up to N_ERR error sources into sticky pending bits and reports them one at a time, highest configured priority first, over a valid/ready handshake. It sits between the error-detect logic and the error-logging/interrupt controller. It is the configurable successor to the fixed 32-source single-cycle priority block.

## Interface
Parameters:
- N_ERR, 32, number of error sources (2..256)
- PRIO_W, 5, priority field width; larger value = higher priority
- CNT_W, 8, drop-counter width (only with the macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- err_in  in  N_ERR  level error requests, sampled every cycle
- err_mask  in  N_ERR  1 = source masked
- cfg_prio  in  N_ERR×PRIO_W  packed, per-source priority
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_idx  out  $clog2(N_ERR)  index of reported source
- rpt_onehot  out  N_ERR  one-hot of rpt_idx
- rpt_prio  out  PRIO_W  cfg_prio of reported source, captured at load
- pending  out  N_ERR  sticky pending register
- drop_clr  in  1  clear drop_cnt (macro only)
- drop_cnt  out  CNT_W  saturating drop count (macro only)

## Operation
- Set: pending[i] <= 1 when err_in[i] & ~err_mask[i].
- Clear: pending[rpt_idx] <= 0 on handshake (rpt_valid & rpt_ready); set wins over clear in the same cycle.
- Masking gates setting only; already-pending bits are retained but excluded from selection while masked.
- Selection (combinational, over pending & ~err_mask): highest cfg_prio wins; ties broken by lowest index.
- FSM, two states:
  - IDLE: if any eligible pending bit, register winner into rpt_idx/rpt_onehot/rpt_prio, rpt_valid <= 1, go REPORT; else stay.
  - REPORT: hold all rpt_* stable until handshake; on handshake rpt_valid <= 0, go IDLE.
- A report in flight is never revoked or replaced: not by higher-priority arrivals, mask changes, or cfg_prio changes.
- Source pending but not eligible (masked) is not reported until unmasked.

## Timing
- Reset values: rpt_valid 0, rpt_idx 0, rpt_onehot 0, rpt_prio 0, pending 0, drop_cnt 0; FSM in IDLE.
- Reset mid-report drops the report and all pending bits.
- err_in asserted in cycle t: pending set at t+1, rpt_valid at t+2 (if FSM in IDLE).
- Handshake in cycle t: rpt_valid low at t+1, next report valid at t+2. Throughput is one report per 2 cycles.
- rpt_valid must not depend combinationally on rpt_ready; all outputs are registered.

## Configuration
- ERR_PRIO_DROP_CNT_EN defined:
  - drop_clr/drop_cnt ports exist.
  - drop_cnt increments by 1 in any cycle where at least one source has err_in & ~err_mask while its pending bit is already 1 and not being cleared that cycle.
  - drop_cnt saturates at all-ones.
  - drop_clr forces 0, and has priority over increment.
- Undefined: ports and counter absent; behaviour otherwise identical.

## Structure
- Package err_prio_pkg: the IDLE/REPORT state enum, and the idx-width helper localparam function.
- Sub-module err_prio_sel: combinational winner select.
  - Inputs: eligible vector, cfg_prio.
  - Outputs: any, idx.
  - Implemented as a log2 tree of (prio, idx) compare nodes with lower-index preference.

## Test plan
- Ordering: cfg_prio[i]=i, err_in=0x0000_0009 pulsed one cycle, rpt_ready=1.
  - First report idx 3, onehot 0x8, prio 3; then idx 0, onehot 0x1; then pending=0, rpt_valid=0.
- Tie-break: all cfg_prio=7, err_in=0x8000_0010 pulsed.
  - Reports idx 4 first, then idx 31.
- Hold: source 5 (prio 2) reporting with rpt_ready=0 for 10 cycles; source 20 (prio 9) asserts meanwhile.
  - rpt_idx stays 5 and stable throughout; after accept, next report is idx 20.
- Set-wins-clear: err_in[5] held high across the accept of idx 5.
  - pending[5] stays 1; idx 5 re-reported two cycles later.
- Mask: err_mask=0x1, err_in=0x1 for 4 cycles.
  - pending stays 0, no rpt_valid.
  - With pending[0] already 1, masking suppresses the report; unmasking produces idx 0 report two cycles later.
- Reset/drop:
  - rst_n low one cycle while rpt_valid=1 gives rpt_valid=0 and pending=0 next cycle.
  - With ERR_PRIO_DROP_CNT_EN, CNT_W=2: holding err_in[3] for 6 cycles with rpt_ready=0 saturates drop_cnt at 3; drop_clr returns it to 0.
